// File: rtl/cfg_mgmt_pkg.sv
// cfg_mgmt_pkg: shared widths, FSM state encoding and constants for the cfg_mgmt responder.
package cfg_mgmt_pkg;
    localparam int CFG_MGMT_ADDR_W = 10;
    localparam int CFG_MGMT_FUNC_W = 8;
    localparam logic [31:0] UNSUPPORTED_FUNC_DATA = 32'hFFFF_FFFF;
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2,
        GAP  = 2'd3
    } state_t;
endpackage

// File: rtl/cfg_mgmt_regfile.sv
// cfg_mgmt_regfile: emulated config dwords with byte-enable writes; dword 0 reads as the fixed ID.
module cfg_mgmt_regfile #(
    parameter int REG_COUNT = 64,
    parameter logic [15:0] VENDOR_ID = 16'h1234,
    parameter logic [15:0] DEVICE_ID = 16'h0001,
    localparam int AW = $clog2(REG_COUNT)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [31:0]   wdata,
    input  logic [3:0]    be,
    input  logic [AW-1:0] raddr,
    output logic [31:0]   rdata
);
    logic [31:0] mem [REG_COUNT];
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < REG_COUNT; i++) mem[i] <= '0;
        end else if (we) begin
            for (int b = 0; b < 4; b++) if (be[b]) mem[waddr][8*b +: 8] <= wdata[8*b +: 8];
        end
    end
    assign rdata = (raddr == '0) ? {DEVICE_ID, VENDOR_ID} : mem[raddr];
endmodule

// File: rtl/cfg_mgmt_responder.sv
// cfg_mgmt_responder: responder end of the cfg_mgmt port with fixed-latency completion.
module cfg_mgmt_responder
    import cfg_mgmt_pkg::*;
#(
    parameter int REG_COUNT = 64,
    parameter int RESP_LATENCY = 2,
    parameter logic [15:0] VENDOR_ID = 16'h1234,
    parameter logic [15:0] DEVICE_ID = 16'h0001
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic [CFG_MGMT_ADDR_W-1:0] cfg_mgmt_addr,
    input  logic [CFG_MGMT_FUNC_W-1:0] cfg_mgmt_function_number,
    input  logic                       cfg_mgmt_write,
    input  logic [31:0]                cfg_mgmt_write_data,
    input  logic [3:0]                 cfg_mgmt_byte_enable,
    input  logic                       cfg_mgmt_read,
    output logic [31:0]                cfg_mgmt_read_data,
    output logic                       cfg_mgmt_read_write_done,
    output logic                       protocol_error,
    output logic [31:0]                write_count
);
    localparam int AW = $clog2(REG_COUNT);
    state_t                     state;
    logic [3:0]                 cnt;
    logic [CFG_MGMT_ADDR_W-1:0] lat_addr;
    logic [CFG_MGMT_FUNC_W-1:0] lat_func;
    logic [31:0]                lat_data;
    logic [3:0]                 lat_be;
    logic                       lat_write;
    logic                       func_ok, in_range, we;
    logic [31:0]                rf_rdata;
    // A simultaneous read+write is latched as a write.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            cnt         <= '0;
            lat_addr    <= '0;
            lat_func    <= '0;
            lat_data    <= '0;
            lat_be      <= '0;
            lat_write   <= 1'b0;
            write_count <= '0;
        end else begin
            unique case (state)
                IDLE: if (cfg_mgmt_read || cfg_mgmt_write) begin
                    lat_addr    <= cfg_mgmt_addr;
                    lat_func    <= cfg_mgmt_function_number;
                    lat_data    <= cfg_mgmt_write_data;
                    lat_be      <= cfg_mgmt_byte_enable;
                    lat_write   <= cfg_mgmt_write;
                    cnt         <= 4'(RESP_LATENCY - 1);
                    state       <= (RESP_LATENCY == 1) ? DONE : BUSY;
                    write_count <= write_count + 32'(cfg_mgmt_write);
                end
                BUSY: begin
                    cnt <= cnt - 4'd1;
                    if (cnt == 4'd1) state <= DONE;
                end
                DONE: state <= GAP;
                GAP:  state <= IDLE;
            endcase
        end
    end
    assign func_ok  = lat_func == '0;
    assign in_range = 32'(lat_addr) < REG_COUNT;
    assign we       = state == DONE && lat_write && func_ok && in_range && lat_addr != '0;
    assign cfg_mgmt_read_write_done = state == DONE;
    assign protocol_error = state == IDLE && cfg_mgmt_read && cfg_mgmt_write;
    assign cfg_mgmt_read_data = (state != DONE || lat_write) ? '0 :
                                !func_ok ? UNSUPPORTED_FUNC_DATA :
                                !in_range ? '0 : rf_rdata;
    cfg_mgmt_regfile #(
        .REG_COUNT(REG_COUNT),
        .VENDOR_ID(VENDOR_ID),
        .DEVICE_ID(DEVICE_ID)
    ) u_regfile (
        .clk(clk),
        .rst_n(rst_n),
        .we(we),
        .waddr(lat_addr[AW-1:0]),
        .wdata(lat_data),
        .be(lat_be),
        .raddr(lat_addr[AW-1:0]),
        .rdata(rf_rdata)
    );
endmodule

// File: tb/tb_cfg_mgmt_responder.sv
// tb_cfg_mgmt_responder: directed checks of latency, register rules, GAP behaviour and mid-op reset.
module tb_cfg_mgmt_responder;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [9:0]  addr = '0;
    logic [7:0]  func = '0;
    logic        wr = 1'b0;
    logic [31:0] wdata = '0;
    logic [3:0]  be = '0;
    logic        rd = 1'b0;
    logic [31:0] rdata;
    logic        done;
    logic        perr;
    logic [31:0] wcount;
    int n_asserts = 0;
    int n_fail = 0;
    logic [31:0] got;

    always #5 clk = ~clk;

    cfg_mgmt_responder dut (
        .clk(clk),
        .rst_n(rst_n),
        .cfg_mgmt_addr(addr),
        .cfg_mgmt_function_number(func),
        .cfg_mgmt_write(wr),
        .cfg_mgmt_write_data(wdata),
        .cfg_mgmt_byte_enable(be),
        .cfg_mgmt_read(rd),
        .cfg_mgmt_read_data(rdata),
        .cfg_mgmt_read_write_done(done),
        .protocol_error(perr),
        .write_count(wcount)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_asserts++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Issues one request, checks the 2-cycle latency and idle-zero read data, returns done-cycle data.
    task automatic op(input logic r, input logic w, input logic [9:0] a, input logic [7:0] f,
                      input logic [31:0] d, input logic [3:0] b, input bit hold, output logic [31:0] res);
        int cyc = 0;
        @(negedge clk);
        rd = r; wr = w; addr = a; func = f; wdata = d; be = b;
        #1 chk("perr_accept", 32'(perr), 32'(r & w));
        res = 'x;
        while (cyc < 20) begin
            @(negedge clk);
            cyc++;
            chk("perr_after", 32'(perr), 0);
            if (done) begin
                res = rdata;
                break;
            end
            chk("rdata_idle", rdata, 0);
        end
        chk("latency", 32'(cyc), 2);
        if (hold) @(negedge clk);
        rd = 1'b0; wr = 1'b0; addr = '0; func = '0; wdata = '0; be = '0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("no_extra_done", 32'(done), 0);
            chk("rdata_zero", rdata, 0);
        end
    endtask

    initial begin
        #2;
        chk("rst_rdata", rdata, 0);
        chk("rst_done", 32'(done), 0);
        chk("rst_perr", 32'(perr), 0);
        chk("rst_wcount", wcount, 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        op(1, 0, 10'd0, 8'd0, 0, 4'h0, 0, got);   chk("read_id", got, 32'h0001_1234);
        op(0, 1, 10'd5, 8'd0, 32'hAABB_CCDD, 4'b0101, 0, got); chk("wr_done_rdata", got, 0);
        chk("wcount1", wcount, 1);
        op(1, 0, 10'd5, 8'd0, 0, 4'h0, 0, got);   chk("read5_be", got, 32'h00BB_00DD);
        op(0, 1, 10'd5, 8'd0, 32'h1111_1111, 4'h0, 0, got);
        chk("wcount2", wcount, 2);
        op(1, 0, 10'd5, 8'd0, 0, 4'h0, 0, got);   chk("read5_be0", got, 32'h00BB_00DD);
        op(0, 1, 10'd0, 8'd0, 32'hFFFF_FFFF, 4'hF, 0, got);
        chk("wcount3", wcount, 3);
        op(1, 0, 10'd0, 8'd0, 0, 4'h0, 0, got);   chk("read_id_ro", got, 32'h0001_1234);
        op(1, 0, 10'd5, 8'd3, 0, 4'h0, 0, got);   chk("read_func3", got, 32'hFFFF_FFFF);
        op(1, 0, 10'd64, 8'd0, 0, 4'h0, 0, got);  chk("read_oor", got, 0);
        op(0, 1, 10'd64, 8'd0, 32'h5, 4'hF, 0, got);
        chk("wcount4", wcount, 4);
        op(1, 1, 10'd7, 8'd0, 32'h1, 4'hF, 0, got); chk("rw_as_write", got, 0);
        chk("wcount5", wcount, 5);
        op(1, 0, 10'd7, 8'd0, 0, 4'h0, 0, got);   chk("read7", got, 32'h1);
        op(1, 0, 10'd5, 8'd0, 0, 4'h0, 1, got);   chk("hold_read5", got, 32'h00BB_00DD);
        chk("wcount_hold", wcount, 5);
        // Reset while BUSY: no completion, and stored dwords revert.
        @(negedge clk);
        wr = 1'b1; addr = 10'd9; wdata = 32'h55; be = 4'hF;
        @(negedge clk);
        chk("busy_no_done", 32'(done), 0);
        rst_n = 1'b0;
        #1 chk("rst_mid_wcount", wcount, 0);
        repeat (3) begin
            @(negedge clk);
            chk("rst_mid_done", 32'(done), 0);
        end
        wr = 1'b0; addr = '0; wdata = '0; be = '0;
        rst_n = 1'b1;
        repeat (3) begin
            @(negedge clk);
            chk("post_rst_done", 32'(done), 0);
        end
        op(1, 0, 10'd5, 8'd0, 0, 4'h0, 0, got);   chk("rst_read5", got, 0);
        op(1, 0, 10'd7, 8'd0, 0, 4'h0, 0, got);   chk("rst_read7", got, 0);
        op(1, 0, 10'd9, 8'd0, 0, 4'h0, 0, got);   chk("rst_read9", got, 0);
        op(1, 0, 10'd0, 8'd0, 0, 4'h0, 0, got);   chk("rst_read_id", got, 32'h0001_1234);
        $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
        $finish;
    end
endmodule
